// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the instruction
// fetch port and the data load/store port, with data priority and a fetch anti-starvation limit.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic             if_elig;
  logic             dm_elig;
  logic             grant_d;
  logic             grant_i;
  logic             done;

  // A requester whose ack is high this cycle is still holding req; it must not be regranted.
  assign if_elig  = if_req & ~if_ack;
  assign dm_elig  = dm_req & ~dm_ack;
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  // Data wins unless a fetch is waiting and the data run has reached its limit.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (dm_elig && (!if_elig || (run < RUN_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
          if (if_req) begin
            run_nxt = (run == RUN_MAX) ? run : run + 1'b1;
          end else begin
            run_nxt = '0;
          end
        end else if (if_elig) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
          run_nxt   = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command is captured at grant and held until completion; acks are single-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (state == BUSY_I) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_ack <= 1'b1;
          if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter: a per-cycle vector table plus hand-written
// sequences for reset abort, fetch starvation and zero-wait back-to-back traffic.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int passCount;
  int checkCount;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        rdy;
    logic [31:0] rd;
    logic        emr;
    logic        ewe;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic        eia;
    logic        eda;
    logic [31:0] eir;
    logic [31:0] edr;
  } vec_t;

  vec_t vecs[14];

  unified_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DATA_RUN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic [31:0] ir, logic [31:0] ia, logic [31:0] dr, logic [31:0] dw,
    logic [31:0] da, logic [31:0] dwd, logic [31:0] dbe, logic [31:0] rdy,
    logic [31:0] rd, logic [31:0] emr, logic [31:0] ewe, logic [31:0] ea,
    logic [31:0] ewd, logic [31:0] ebe, logic [31:0] eia, logic [31:0] eda,
    logic [31:0] eir, logic [31:0] edr);
    vec_t v;
    v.ir  = ir[0];
    v.ia  = ia;
    v.dr  = dr[0];
    v.dw  = dw[0];
    v.da  = da;
    v.dwd = dwd;
    v.dbe = dbe[3:0];
    v.rdy = rdy[0];
    v.rd  = rd;
    v.emr = emr[0];
    v.ewe = ewe[0];
    v.ea  = ea;
    v.ewd = ewd;
    v.ebe = ebe[3:0];
    v.eia = eia[0];
    v.eda = eda[0];
    v.eir = eir;
    v.edr = edr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req    = v.ir;
    if_addr   = v.ia;
    dm_req    = v.dr;
    dm_we     = v.dw;
    dm_addr   = v.da;
    dm_wdata  = v.dwd;
    dm_be     = v.dbe;
    mem_ready = v.rdy;
    mem_rdata = v.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit withFetch[10];
    bit expectData[10];
    passCount  = 0;
    checkCount = 0;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_be     = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset values
    #12;
    checkOutput("reset mem_req",   32'(mem_req),   32'd0);
    checkOutput("reset mem_we",    32'(mem_we),    32'd0);
    checkOutput("reset mem_addr",  mem_addr,       32'd0);
    checkOutput("reset mem_wdata", mem_wdata,      32'd0);
    checkOutput("reset mem_be",    32'(mem_be),    32'd0);
    checkOutput("reset if_ack",    32'(if_ack),    32'd0);
    checkOutput("reset dm_ack",    32'(dm_ack),    32'd0);
    checkOutput("reset if_rdata",  if_rdata,       32'd0);
    checkOutput("reset dm_rdata",  dm_rdata,       32'd0);
    checkOutput("reset if_stall",  32'(if_stall),  32'd0);
    rst = 1'b0;

    // Reset while BUSY_D abandons the load without an ack
    dm_req  = 1'b1;
    dm_addr = 32'h5000;
    dm_be   = 4'hF;
    tick();
    checkOutput("abort mem_req before reset", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort mem_req in reset", 32'(mem_req), 32'd0);
    checkOutput("abort dm_ack in reset",  32'(dm_ack),  32'd0);
    checkOutput("abort if_ack in reset",  32'(if_ack),  32'd0);
    dm_req    = 1'b0;
    mem_ready = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("abort c%0d dm_ack", i),  32'(dm_ack),  32'd0);
      checkOutput($sformatf("abort c%0d mem_req", i), 32'(mem_req), 32'd0);
    end
    mem_ready = 1'b0;

    // Lone fetch with two wait cycles, simultaneous fetch/load, then a store
    vecs[0]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h100, 0, 'hF, 0, 0, 0, 0);
    vecs[1]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h100, 0, 'hF, 0, 0, 0, 0);
    vecs[2]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h100, 0, 'hF, 0, 0, 0, 0);
    vecs[3]  = mk(1, 'h100, 0, 0, 0, 0, 0, 1, 'h00500093, 0, 0, 0, 0, 0, 1, 0, 'h00500093, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 'h00500093, 0);
    vecs[5]  = mk(1, 'h104, 1, 0, 'h2000, 0, 'hF, 0, 0, 1, 0, 'h2000, 0, 'hF, 0, 0, 'h00500093, 0);
    vecs[6]  = mk(1, 'h104, 1, 0, 'h2000, 0, 'hF, 1, 'h11112222, 0, 0, 0, 0, 0, 0, 1, 'h00500093, 'h11112222);
    vecs[7]  = mk(1, 'h104, 1, 0, 'h2000, 0, 'hF, 0, 0, 1, 0, 'h104, 0, 'hF, 0, 0, 'h00500093, 'h11112222);
    vecs[8]  = mk(1, 'h104, 0, 0, 0, 0, 0, 1, 'h00A00113, 0, 0, 0, 0, 0, 1, 0, 'h00A00113, 'h11112222);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00A00113, 'h11112222);
    vecs[10] = mk(0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 'h00A00113, 'h11112222);
    vecs[11] = mk(0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 0, 0, 'h00A00113, 'h11112222);
    vecs[12] = mk(0, 0, 1, 1, 'h3004, 'hDEADBEEF, 'h3, 1, 'hBAD0BAD0, 0, 0, 0, 0, 0, 0, 1, 'h00A00113, 'h11112222);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00A00113, 'h11112222);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d mem_req", i),  32'(mem_req),  32'(vecs[i].emr));
      checkOutput($sformatf("v%0d if_ack", i),   32'(if_ack),   32'(vecs[i].eia));
      checkOutput($sformatf("v%0d dm_ack", i),   32'(dm_ack),   32'(vecs[i].eda));
      checkOutput($sformatf("v%0d if_rdata", i), if_rdata,      vecs[i].eir);
      checkOutput($sformatf("v%0d dm_rdata", i), dm_rdata,      vecs[i].edr);
      checkOutput($sformatf("v%0d if_stall", i), 32'(if_stall), 32'(vecs[i].ir & ~vecs[i].eia));
      checkOutput($sformatf("v%0d dm_stall", i), 32'(dm_stall), 32'(vecs[i].dr & ~vecs[i].eda));
      if (vecs[i].emr) begin
        checkOutput($sformatf("v%0d mem_we", i),   32'(mem_we),   32'(vecs[i].ewe));
        checkOutput($sformatf("v%0d mem_addr", i), mem_addr,      vecs[i].ea);
        checkOutput($sformatf("v%0d mem_be", i),   32'(mem_be),   32'(vecs[i].ebe));
        if (vecs[i].ewe) begin
          checkOutput($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ewd);
        end
      end
    end

    // Data run limit: a data-only grant clears the run, four data grants with a fetch
    // waiting force the fetch next, and the fetch grant restarts the run from zero.
    withFetch  = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    expectData = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    for (int r = 0; r < 10; r++) begin
      if_req    = withFetch[r];
      if_addr   = 32'h200 + 32'(r) * 4;
      dm_req    = 1'b1;
      dm_we     = 1'b0;
      dm_addr   = 32'h4000 + 32'(r) * 4;
      dm_be     = 4'hF;
      mem_ready = 1'b0;
      tick();
      checkOutput($sformatf("run r%0d mem_req", r), 32'(mem_req), 32'd1);
      checkOutput($sformatf("run r%0d grant addr", r), mem_addr, expectData[r] ? dm_addr : if_addr);
      mem_ready = 1'b1;
      mem_rdata = 32'h7000 + 32'(r);
      tick();
      checkOutput($sformatf("run r%0d dm_ack", r), 32'(dm_ack), 32'(expectData[r]));
      checkOutput($sformatf("run r%0d if_ack", r), 32'(if_ack), 32'(!expectData[r]));
      if (expectData[r]) begin
        checkOutput($sformatf("run r%0d dm_rdata", r), dm_rdata, 32'h7000 + 32'(r));
      end
      if_req    = 1'b0;
      dm_req    = 1'b0;
      mem_ready = 1'b0;
      tick();
      checkOutput($sformatf("run r%0d idle mem_req", r), 32'(mem_req), 32'd0);
    end

    // Zero-wait memory with both ports requesting continuously: D and I alternate,
    // each transaction takes two cycles and every ack is a single-cycle pulse.
    if_req    = 1'b1;
    if_addr   = 32'h300;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h6000;
    mem_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      mem_rdata = 32'hA000 + 32'(k);
      tick();
      if ((k % 2) == 0) begin
        checkOutput($sformatf("zw k%0d mem_req", k), 32'(mem_req), 32'd1);
        checkOutput($sformatf("zw k%0d mem_addr", k), mem_addr, ((k % 4) == 0) ? 32'h6000 : 32'h300);
        checkOutput($sformatf("zw k%0d acks", k), {30'd0, if_ack, dm_ack}, 32'd0);
      end else begin
        checkOutput($sformatf("zw k%0d mem_req", k), 32'(mem_req), 32'd0);
        checkOutput($sformatf("zw k%0d dm_ack", k), 32'(dm_ack), 32'((k % 4) == 1));
        checkOutput($sformatf("zw k%0d if_ack", k), 32'(if_ack), 32'((k % 4) == 3));
        if ((k % 4) == 1) begin
          checkOutput($sformatf("zw k%0d dm_rdata", k), dm_rdata, 32'hA000 + 32'(k));
        end else begin
          checkOutput($sformatf("zw k%0d if_rdata", k), if_rdata, 32'hA000 + 32'(k));
        end
      end
      checkOutput($sformatf("zw k%0d dm_stall", k), 32'(dm_stall), 32'(!((k % 4) == 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
